phys_reg_free_list: RTL and testbench

Parametrised physical-register free list for the rename stage of the out-of-order core. It is a circular buffer of free physical register IDs. It supports:
- one allocation per cycle to rename;
- one release per cycle from ROB commit;
- single-cycle recovery on flush to the architecturally committed allocation point.

This block replaces the fixed-size free list. Register-file size, architectural register count and buffer depth are all parameters.

---
 rtl/phys_reg_free_list_if.sv | 28 ++
 rtl/phys_reg_free_list.sv | 65 ++++++
 tb/tb_phys_reg_free_list.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit-side signal bundle for the physical-register free list.
// The slave modport is the free list; the master modport is the rename/ROB side.
interface phys_reg_free_list_if #(
  parameter int PREG_W = 6,
  parameter int CNT_W  = 7
);
  logic              alloc_req;
  logic              alloc_valid;
  logic [PREG_W-1:0] alloc_preg;
  logic              free_valid;
  logic [PREG_W-1:0] free_preg;
  logic              commit_alloc;
  logic              flush;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow_err;

  modport master (
    output alloc_req, free_valid, free_preg, commit_alloc, flush,
    input  alloc_valid, alloc_preg, count, full, empty, overflow_err
  );

  modport slave (
    input  alloc_req, free_valid, free_preg, commit_alloc, flush,
    output alloc_valid, alloc_preg, count, full, empty, overflow_err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register IDs with speculative head, retired
// head and tail pointers; flush rewinds the speculative head in one cycle.
module phys_reg_free_list #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  parameter int DEPTH     = 64,
  parameter int PREG_W    = $clog2(PHYS_REGS)
) (
  input logic                  clk,
  input logic                  rst,
  phys_reg_free_list_if.slave  fl
);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int PTR_W     = IDX_W + 1;
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int FREE_INIT = PHYS_REGS - ARCH_REGS;

  logic [PREG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  rhead;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  occ;
  logic [PTR_W-1:0]  rhead_next;
  logic              alloc_do;
  logic              free_do;

  // Pointers carry a wrap bit, so the difference is the occupancy directly.
  assign occ            = tail - head;
  assign fl.count       = CNT_W'(occ);
  assign fl.empty       = (occ == '0);
  assign fl.full        = (occ == PTR_W'(DEPTH));
  assign fl.alloc_valid = !fl.empty;
  assign fl.alloc_preg  = mem[head[IDX_W-1:0]];

  assign alloc_do   = fl.alloc_req && !fl.empty && !fl.flush;
  assign free_do    = fl.free_valid && !fl.full;
  assign rhead_next = rhead + PTR_W'(fl.commit_alloc);

  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      rhead           <= '0;
      tail            <= PTR_W'(FREE_INIT);
      fl.overflow_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i < FREE_INIT) ? PREG_W'(ARCH_REGS + i) : '0;
      end
    end else begin
      // Flush lands on the retired head, including a commit in the same cycle.
      if (fl.flush) begin
        head <= rhead_next;
      end else if (alloc_do) begin
        head <= head + PTR_W'(1);
      end
      rhead <= rhead_next;
      if (free_do) begin
        mem[tail[IDX_W-1:0]] <= fl.free_preg;
        tail                 <= tail + PTR_W'(1);
      end
      if (fl.free_valid && fl.full) begin
        fl.overflow_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios plus randomized traffic,
// compared each cycle against an unbounded-sequence reference model.
module tb_phys_reg_free_list;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int DEPTH     = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phys_reg_free_list_if #(.PREG_W(6), .CNT_W(7)) bus ();

  phys_reg_free_list #(
    .PHYS_REGS(PHYS_REGS),
    .ARCH_REGS(ARCH_REGS),
    .DEPTH    (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fl (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: every preg ever enqueued, in order; head/rhead are absolute positions
  // into that sequence and the tail is simply its length.
  int hist[$];
  int m_head;
  int m_rhead;
  bit m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    return hist.size() - m_head;
  endfunction

  task automatic m_reset();
    hist.delete();
    for (int i = 0; i < PHYS_REGS - ARCH_REGS; i++) hist.push_back(ARCH_REGS + i);
    m_head  = 0;
    m_rhead = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    int c;
    c = m_count();
    chk({tag, ".count"}, 32'(bus.count), c);
    chk({tag, ".valid"}, 32'(bus.alloc_valid), 32'(c > 0));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(c == 0));
    chk({tag, ".full"},  32'(bus.full), 32'(c == DEPTH));
    chk({tag, ".ovf"},   32'(bus.overflow_err), 32'(m_ovf));
    if (c > 0) chk({tag, ".preg"}, 32'(bus.alloc_preg), hist[m_head]);
  endtask

  task automatic cycle(input bit areq, input bit fv, input int fp,
                       input bit ca, input bit fls, input bit r, input string tag);
    int  c;
    int  new_rhead;
    bit  do_alloc;
    c                = m_count();
    rst              = r;
    bus.alloc_req    = areq;
    bus.free_valid   = fv;
    bus.free_preg    = 6'(fp);
    bus.commit_alloc = ca;
    bus.flush        = fls;
    @(posedge clk);
    if (r) begin
      m_reset();
    end else begin
      do_alloc  = areq && (c > 0) && !fls;
      new_rhead = m_rhead + (ca ? 1 : 0);
      if (fv && c < DEPTH) hist.push_back(fp);
      if (fv && c == DEPTH) m_ovf = 1'b1;
      if (fls) m_head = new_rhead;
      else if (do_alloc) m_head = m_head + 1;
      m_rhead = new_rhead;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_reset();
    cycle(0, 0, 0, 0, 0, 1, "reset");
    rst = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    bus.alloc_req    = 1'b0;
    bus.free_valid   = 1'b0;
    bus.free_preg    = '0;
    bus.commit_alloc = 1'b0;
    bus.flush        = 1'b0;
    m_reset();

    // Reset state and drain all initially free pregs in order.
    idle_reset();
    chk("rst_count", 32'(bus.count), 32);
    chk("rst_preg", 32'(bus.alloc_preg), 32);
    for (int i = 0; i < 32; i++) begin
      chk("drain_seq", 32'(bus.alloc_preg), 32 + i);
      cycle(1, 0, 0, 0, 0, 0, "drain");
    end
    chk("drain_empty", 32'(bus.empty), 1);
    cycle(1, 0, 0, 0, 0, 0, "alloc_when_empty");
    chk("empty_hold", 32'(bus.count), 0);

    // Alloc and free together while empty: only the free lands.
    cycle(1, 1, 5, 0, 0, 0, "alloc_free_empty");
    chk("refill_preg", 32'(bus.alloc_preg), 5);
    chk("refill_count", 32'(bus.count), 1);

    // Flush rewinds to the retired head.
    idle_reset();
    repeat (4) cycle(1, 0, 0, 0, 0, 0, "pre_flush_alloc");
    repeat (2) cycle(0, 0, 0, 1, 0, 0, "commit");
    cycle(0, 0, 0, 0, 1, 0, "flush");
    chk("flush_preg", 32'(bus.alloc_preg), 34);
    chk("flush_count", 32'(bus.count), 30);
    cycle(1, 0, 0, 0, 1, 0, "flush_alloc");
    chk("flush_alloc_preg", 32'(bus.alloc_preg), 34);

    // Flush coinciding with a commit.
    idle_reset();
    repeat (3) cycle(1, 0, 0, 0, 0, 0, "pre_flush_alloc2");
    cycle(0, 0, 0, 1, 1, 0, "flush_commit");
    chk("flush_commit_preg", 32'(bus.alloc_preg), 33);
    chk("flush_commit_count", 32'(bus.count), 31);

    // Fill to full, overflow, then wrap all the way around.
    idle_reset();
    for (int i = 0; i < 32; i++) cycle(0, 1, i, 0, 0, 0, "fill");
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 64);
    cycle(0, 1, 7, 0, 0, 0, "overflow");
    chk("overflow_set", 32'(bus.overflow_err), 1);
    for (int i = 0; i < 64; i++) begin
      chk("wrap_seq", 32'(bus.alloc_preg), (i < 32) ? 32 + i : i - 32);
      cycle(1, 0, 0, 0, 0, 0, "wrap");
    end
    chk("wrap_empty", 32'(bus.empty), 1);
    chk("overflow_sticky", 32'(bus.overflow_err), 1);

    // Randomized traffic with occasional flushes and mid-stream resets.
    idle_reset();
    for (int n = 0; n < 3000; n++) begin
      bit r, fls, areq, ca, fv;
      r    = ($urandom_range(0, 199) == 0);
      fls  = ($urandom_range(0, 19) == 0);
      areq = ($urandom_range(0, 3) != 0);
      ca   = (m_rhead < m_head) && ($urandom_range(0, 1) == 1);
      fv   = ($urandom_range(0, 2) != 0) && (hist.size() - m_rhead < DEPTH);
      cycle(areq, fv, int'($urandom_range(0, PHYS_REGS - 1)), ca, fls, r, "rand");
      if (r) begin
        chk("rand_rst_count", 32'(bus.count), 32);
        chk("rand_rst_preg", 32'(bus.alloc_preg), 32);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
